// File: rtl/bit_serial_mult_driver_if.sv
// Operand/result handshake and serial multiplier link for bit_serial_mult_driver.
// The master side is the operand source, result sink and serial multiplier.
interface bit_serial_mult_driver_if #(
    parameter int N = 4
);
    localparam int K = 2 * N;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] out_p;
    logic         x;
    logic         y;
    logic         first_bit;
    logic         last_bit;
    logic         p;

    modport master (
        output in_valid, in_a, in_b, out_ready, p,
        input  in_ready, out_valid, out_p, x, y, first_bit, last_bit
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, p,
        output in_ready, out_valid, out_p, x, y, first_bit, last_bit
    );
endinterface

// File: rtl/bit_serial_mult_driver.sv
// Serializes a signed operand pair LSB-first into a bit-serial multiplier and
// collects the returned product bits into a parallel 2N-bit result.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// SHIFT | K serial cycles, product bit p captured each cycle
// FLUSH | 2 cycles with sign bits held, p ignored
// DONE  | result presented until out_ready
module bit_serial_mult_driver #(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    bit_serial_mult_driver_if.slave  bus
);
    localparam int K  = 2 * N;
    localparam int CW = $clog2(K);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [K-1:0]    result_q, result_d;
    logic [K-1:0]    out_p_q, out_p_d;
    logic            x_q, x_d;
    logic            y_q, y_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [IW-1:0]   sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            out_p_q     <= '0;
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            out_p_q     <= out_p_d;
            x_q         <= x_d;
            y_q         <= y_d;
            first_q     <= first_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        out_p_d  = out_p_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                end
            end
            SHIFT: begin
                result_d[cnt_q] = bus.p;
                if (cnt_q == CW'(K - 1)) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    out_p_d = result_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the upcoming state and count.
    always_comb begin
        sel = IW'(N - 1);
        if (state_d == SHIFT && cnt_d < CW'(N - 1)) begin
            sel = IW'(cnt_d);
        end
        x_d = 1'b0;
        y_d = 1'b0;
        if (state_d == SHIFT || state_d == FLUSH) begin
            x_d = a_d[sel];
            y_d = b_d[sel];
        end
        first_d     = (state_d == SHIFT) && (cnt_d == '0);
        last_d      = !(state_d == SHIFT || state_d == FLUSH);
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.first_bit = first_q;
    assign bus.last_bit  = last_q;
endmodule

// File: tb/tb_bit_serial_mult_driver.sv
// Directed bench for bit_serial_mult_driver with a behavioural bit-serial multiplier
// answering on p.
module tb_bit_serial_mult_driver;
    localparam int N = 4;
    localparam int K = 2 * N;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;
    int   acc_cyc = 0;

    bit_serial_mult_driver_if #(.N(N)) bus ();

    bit_serial_mult_driver #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Multiplier model: p is bit idx of the product of the operand bits seen so far.
    logic [7:0] mx = '0;
    logic [7:0] my = '0;
    int         midx = 8;
    logic [7:0] tx, ty, tp;
    int         ti;

    always @(posedge clk) begin
        if (bus.first_bit === 1'b1) begin
            mx   <= {7'b0, bus.x};
            my   <= {7'b0, bus.y};
            midx <= 1;
        end else if (bus.last_bit === 1'b0 && midx < 8) begin
            mx[midx] <= bus.x;
            my[midx] <= bus.y;
            midx     <= midx + 1;
        end
    end

    always_comb begin
        tx = (bus.first_bit === 1'b1) ? 8'h00 : mx;
        ty = (bus.first_bit === 1'b1) ? 8'h00 : my;
        ti = (bus.first_bit === 1'b1) ? 0 : midx;
        tp = 8'h00;
        bus.p = 1'b0;
        if (ti < 8) begin
            tx[ti] = bus.x;
            ty[ti] = bus.y;
            tp = tx * ty;
            bus.p = tp[ti];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [3:0] a, input logic [3:0] b);
        chk("accept_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        cyc();
        acc_cyc      = cyc_cnt;
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
    endtask

    task automatic wait_out(output int lat, output int fb, output int lb);
        lat = 0;
        fb  = 0;
        lb  = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            fb += int'(bus.first_bit === 1'b1);
            lb += int'(bus.last_bit === 1'b0);
            cyc();
            lat++;
        end
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input string tag);
        int lat, fb, lb;
        bus.out_ready = 1'b1;
        accept(a, b);
        wait_out(lat, fb, lb);
        chk({tag, "_latency"}, 32'(lat), 32'(K + 2));
        chk({tag, "_first_bit_cycles"}, 32'(fb), 32'd1);
        chk({tag, "_last_bit_low_cycles"}, 32'(lb), 32'(K + 2));
        chk({tag, "_out_p"}, 32'(bus.out_p), 32'(exp));
        cyc();
        chk({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int lat, fb, lb, rises, prev_acc;
        logic [7:0] iv;
        logic [7:0] ref_p;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) cyc();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_last_bit", 32'(bus.last_bit), 32'd1);
        chk("rst_first_bit", 32'(bus.first_bit), 32'd0);
        chk("rst_out_p", 32'(bus.out_p), 32'd0);
        chk("rst_xy", 32'({bus.x, bus.y}), 32'd0);
        reset = 1'b0;
        cyc();

        run_op(4'd5, 4'd7, 8'h23, "p5x7");
        run_op(4'hD, 4'd5, 8'hF1, "pm3x5");
        run_op(4'd1, 4'h8, 8'hF8, "p1xm8");
        run_op(4'h8, 4'h8, 8'h40, "pm8xm8");

        // Backpressure: result must hold and new operands must be refused.
        bus.out_ready = 1'b0;
        accept(4'd6, 4'hE);
        wait_out(lat, fb, lb);
        chk("bp_latency", 32'(lat), 32'(K + 2));
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 4'd3;
            bus.in_b     = 4'd3;
            cyc();
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out_p", 32'(bus.out_p), 32'hF4);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_last_bit", 32'(bus.last_bit), 32'd1);
            chk("bp_first_bit", 32'(bus.first_bit), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        run_op(4'd3, 4'hE, 8'hFA, "p3xm2");

        // Reset in the middle of a frame at SHIFT count 3.
        accept(4'd7, 4'd7);
        repeat (3) cyc();
        chk("midrst_last_bit_before", 32'(bus.last_bit), 32'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_last_bit", 32'(bus.last_bit), 32'd1);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_first_bit", 32'(bus.first_bit), 32'd0);
        chk("midrst_out_p", 32'(bus.out_p), 32'd0);
        rises = 0;
        for (int i = 0; i < 15; i++) begin
            rises += int'(bus.out_valid !== 1'b0);
            cyc();
        end
        chk("midrst_out_valid_never", 32'(rises), 32'd0);
        run_op(4'd2, 4'd3, 8'h06, "p2x3");

        // Exhaustive back-to-back sweep against signed multiply.
        prev_acc = 0;
        for (int i = 0; i < 256; i++) begin
            iv    = 8'(i);
            ref_p = 8'({{4{iv[7]}}, iv[7:4]} * {{4{iv[3]}}, iv[3:0]});
            run_op(iv[7:4], iv[3:0], ref_p, "sweep");
            if (i > 0) begin
                chk("sweep_period", 32'(acc_cyc - prev_acc), 32'(K + 4));
            end
            prev_acc = acc_cyc;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
